vertex_transform_ctrl: RTL and testbench

Sequencing controller that applies the stored 4x4 fixed-point MVP matrix to a stream of homogeneous vertices. It time-shares one 4-term dot-product datapath across the four matrix rows, one row per cycle. It holds the matrix in a word-writable register file, accepts vertices on a valid/ready handshake, and presents transformed vertices downstream to the rasteriser front end.

---
 rtl/vertex_transform_ctrl_if.sv | 26 ++
 rtl/vertex_transform_ctrl.sv | 109 ++++++++++
 tb/tb_vertex_transform_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/vertex_transform_ctrl_if.sv
// Handshake bundle for the vertex transform controller: matrix write port,
// vertex input stream and transformed vertex output stream.
interface vertex_transform_ctrl_if #(
  parameter int W = 16
);
  logic           mat_we;
  logic [3:0]     mat_idx;
  logic [W-1:0]   mat_data;
  logic           mat_ready;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] in_vec;
  logic           out_valid;
  logic           out_ready;
  logic [4*W-1:0] out_vec;

  modport master (
    output mat_we, mat_idx, mat_data, in_valid, in_vec, out_ready,
    input  mat_ready, in_ready, out_valid, out_vec
  );

  modport slave (
    input  mat_we, mat_idx, mat_data, in_valid, in_vec, out_ready,
    output mat_ready, in_ready, out_valid, out_vec
  );
endinterface

// File: rtl/vertex_transform_ctrl.sv
// Applies a stored 4x4 fixed-point matrix to homogeneous vertices, sharing one
// 4-term dot-product datapath across the rows, one row per cycle.
module vertex_transform_ctrl #(
  parameter int W         = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  vertex_transform_ctrl_if.slave bus,
  output logic                  busy,
  output logic                  ovf_sticky,
  input  logic                  ovf_clr
);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  localparam logic signed [W-1:0]     ONE  = W'(1) << FRAC_BITS;
  localparam logic signed [2*W+1:0]   MAXV = {{(W+3){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W+1:0]   MINV = {{(W+3){1'b1}}, {(W-1){1'b0}}};

  state_t                 state;
  logic [1:0]             row;
  logic signed [W-1:0]    mat [16];
  logic signed [W-1:0]    vtx [4];
  logic [4*W-1:0]         res_vec;
  logic                   out_valid_r;

  logic signed [2*W-1:0]  prod [4];
  logic signed [2*W+1:0]  sum;
  logic signed [2*W+1:0]  shifted;
  logic                   ovf_row;

  function automatic logic signed [2*W-1:0] sext(input logic signed [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  function automatic logic signed [W-1:0] sat_val(input logic signed [2*W+1:0] v);
    if (v > MAXV)      return MAXV[W-1:0];
    else if (v < MINV) return MINV[W-1:0];
    else               return v[W-1:0];
  endfunction

  function automatic logic sat_ovf(input logic signed [2*W+1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  // Dot product of the current matrix row with the latched vertex; products are
  // full precision and only the shifted sum is saturated.
  always_comb begin
    sum = '0;
    for (int c = 0; c < 4; c++) begin
      prod[c] = sext(mat[{row, c[1:0]}]) * sext(vtx[c]);
      sum     = sum + {{2{prod[c][2*W-1]}}, prod[c]};
    end
    shifted = sum >>> FRAC_BITS;
    ovf_row = sat_ovf(shifted);
  end

  assign bus.mat_ready = (state == IDLE);
  assign bus.in_ready  = (state == IDLE) && !bus.mat_we;
  assign bus.out_valid = out_valid_r;
  assign bus.out_vec   = res_vec;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      row         <= 2'd0;
      res_vec     <= '0;
      out_valid_r <= 1'b0;
      busy        <= 1'b0;
      ovf_sticky  <= 1'b0;
      for (int i = 0; i < 4; i++) vtx[i] <= '0;
      for (int i = 0; i < 16; i++) mat[i] <= (i % 5 == 0) ? ONE : '0;
    end else begin
      // A saturation in CALC below overrides a clear on the same edge.
      if (ovf_clr) ovf_sticky <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mat_we) begin
            mat[bus.mat_idx] <= bus.mat_data;
          end else if (bus.in_valid) begin
            for (int i = 0; i < 4; i++) vtx[i] <= bus.in_vec[W*i +: W];
            row   <= 2'd0;
            state <= CALC;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          res_vec[row*W +: W] <= sat_val(shifted);
          if (ovf_row) ovf_sticky <= 1'b1;
          row <= row + 2'd1;
          if (row == 2'd3) begin
            state       <= OUT;
            out_valid_r <= 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_transform_ctrl.sv
// Directed bench for vertex_transform_ctrl with an expected-output queue.
module tb_vertex_transform_ctrl;

  localparam int W = 16;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic ovf_clr = 1'b0;
  logic busy, ovf_sticky;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [4*W-1:0] sb [$];

  vertex_transform_ctrl_if #(.W(W)) bus ();

  vertex_transform_ctrl #(.W(W), .FRAC_BITS(8)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .bus        (bus),
    .busy       (busy),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
  );

  always #5 Clk = ~Clk;

  function automatic logic [4*W-1:0] vec(input logic [W-1:0] x, y, z, w);
    return {w, z, y, x};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    step();
  endtask

  task automatic mat_write(input logic [3:0] idx, input logic [W-1:0] data);
    bus.mat_we   = 1'b1;
    bus.mat_idx  = idx;
    bus.mat_data = data;
    step();
    bus.mat_we   = 1'b0;
  endtask

  task automatic send(input logic [4*W-1:0] v, input logic [4*W-1:0] exp, input bit push);
    bit done = 0;
    bus.in_vec   = v;
    bus.in_valid = 1'b1;
    if (push) sb.push_back(exp);
    for (int k = 0; k < 20 && !done; k++) begin
      if (bus.in_ready) done = 1;
      step();
    end
    bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic recv(input int hold);
    bit seen = 0;
    logic [4*W-1:0] exp;
    bus.out_ready = (hold == 0);
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.out_valid) seen = 1;
      else step();
    end
    if (!seen) begin
      chk("recv_timeout", 0, 1);
    end else begin
      if (sb.size() == 0) begin
        chk("sb_empty", 0, 1);
        exp = '0;
      end else begin
        exp = sb.pop_front();
      end
      chk("out_vec", bus.out_vec, exp);
      for (int k = 0; k < hold; k++) begin
        bus.mat_we   = (k < 5);
        bus.mat_idx  = 4'd0;
        bus.mat_data = '0;
        #1;
        chk("hold_in_ready", bus.in_ready, 0);
        chk("hold_mat_ready", bus.mat_ready, 0);
        step();
        chk("hold_out_vec", bus.out_vec, exp);
        chk("hold_out_valid", bus.out_valid, 1);
      end
      bus.mat_we    = 1'b0;
      bus.out_ready = 1'b1;
      step();
      chk("post_out_valid", bus.out_valid, 0);
      chk("post_busy", busy, 0);
    end
  endtask

  initial begin
    bus.mat_we    = 1'b0;
    bus.mat_idx   = '0;
    bus.mat_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b1;
    #3;
    do_reset();

    // Reset state
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_vec", bus.out_vec, 0);
    chk("rst_ovf", ovf_sticky, 0);
    chk("rst_mat_ready", bus.mat_ready, 1);
    chk("rst_in_ready", bus.in_ready, 1);

    // 1: identity pass-through and latency
    send(vec(16'h0100, 16'h0200, 16'hFF00, 16'h0100),
         vec(16'h0100, 16'h0200, 16'hFF00, 16'h0100), 1);
    chk("t1_busy", busy, 1);
    chk("t1_mat_ready_calc", bus.mat_ready, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t1_early_valid", bus.out_valid, 0);
    end
    step();
    chk("t1_valid_t4", bus.out_valid, 1);
    recv(0);
    chk("t1_ovf", ovf_sticky, 0);

    // 2: scaled diagonal with translation term
    mat_write(4'd0, 16'h0200);
    mat_write(4'd5, 16'h0200);
    mat_write(4'd10, 16'h0200);
    mat_write(4'd15, 16'h0100);
    mat_write(4'd3, 16'h0300);
    send(vec(16'h0100, 16'h0200, 16'h0300, 16'h0100),
         vec(16'h0500, 16'h0400, 16'h0600, 16'h0100), 1);
    recv(0);

    // 3: positive and negative saturation, sticky flag
    mat_write(4'd0, 16'h7FFF);
    send(vec(16'h7FFF, 0, 0, 0), vec(16'h7FFF, 0, 0, 0), 1);
    recv(0);
    chk("t3_ovf_pos", ovf_sticky, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", ovf_sticky, 0);
    send(vec(16'h8000, 0, 0, 0), vec(16'h8000, 0, 0, 0), 1);
    recv(0);
    chk("t3_ovf_neg", ovf_sticky, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr2", ovf_sticky, 0);
    send(vec(16'h8000, 0, 0, 0), vec(16'h8000, 0, 0, 0), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t3_set_wins", ovf_sticky, 1);
    recv(0);

    // 4: back-pressure in OUT; ignored matrix write
    do_reset();
    send(vec(16'h0300, 16'hFD00, 16'h0040, 16'h0100),
         vec(16'h0300, 16'hFD00, 16'h0040, 16'h0100), 1);
    recv(10);
    send(vec(16'h0123, 16'h0456, 16'hF789, 16'h0100),
         vec(16'h0123, 16'h0456, 16'hF789, 16'h0100), 1);
    recv(0);

    // 5: write wins over a simultaneous vertex
    bus.mat_we   = 1'b1;
    bus.mat_idx  = 4'd0;
    bus.mat_data = 16'h0200;
    bus.in_vec   = vec(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    bus.in_valid = 1'b1;
    #1;
    chk("t5_in_ready_blocked", bus.in_ready, 0);
    step();
    bus.mat_we = 1'b0;
    #1;
    chk("t5_busy_idle", busy, 0);
    chk("t5_in_ready_next", bus.in_ready, 1);
    sb.push_back(vec(16'h0200, 16'h0100, 16'h0100, 16'h0100));
    step();
    bus.in_valid = 1'b0;
    chk("t5_busy", busy, 1);
    recv(0);

    // 6: reset in the middle of CALC
    mat_write(4'd0, 16'h0300);
    send(vec(16'h0100, 16'h0100, 16'h0100, 16'h0100), '0, 0);
    step();
    step();
    Reset_n = 1'b0;
    #1;
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_busy", busy, 0);
    #2;
    Reset_n = 1'b1;
    step();
    send(vec(16'h1234, 16'hFEDC, 16'h0080, 16'h8000),
         vec(16'h1234, 16'hFEDC, 16'h0080, 16'h8000), 1);
    recv(0);
    chk("t6_ovf", ovf_sticky, 0);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
